case_3_mul_pipe_hs: RTL and testbench
=====================================

CASE_3_MUL_PIPE_HS -- requirements
Module: case_3_mul_pipe_hs

Interface
REQ-001 Parameter ID, default 1, instance tag with no functional effect.
REQ-002 Parameter NUM_STAGE, default 3, pipeline depth in cycles; legal range 1..8.
REQ-003 Parameter din0_WIDTH, default 14, operand A width.
REQ-004 Parameter din1_WIDTH, default 12, operand B width.
REQ-005 Parameter dout_WIDTH, default 26, result width; legal range 2..din0_WIDTH+din1_WIDTH.
REQ-006 Port clk, input, 1, single clock; all logic SHALL be on its rising edge.
REQ-007 Port reset, input, 1, synchronous and active-high reset.
REQ-008 Port ce, input, 1, clock enable; when ce=0 all state SHALL hold and in_ready SHALL read 0.
REQ-009 Port in_valid, input, 1, operands are presented.
REQ-010 Port in_ready, output, 1, the block accepts operands this cycle.
REQ-011 Port op_signed, input, 1, operand mode: 1 treats both operands as signed, 0 as unsigned; sampled with the operands.
REQ-012 Port din0, input, din0_WIDTH, operand A.
REQ-013 Port din1, input, din1_WIDTH, operand B.
REQ-014 Port out_valid, output, 1, dout holds a result.
REQ-015 Port out_ready, input, 1, the downstream block accepts the result.
REQ-016 Port dout, output, dout_WIDTH, product.
REQ-017 Port ovf, output, 1, the full product did not fit in dout_WIDTH; qualified by out_valid.

Function
REQ-018 The full product SHALL be computed at P = din0_WIDTH+din1_WIDTH bits, sign- or zero-extended according to op_signed.
REQ-019 Advance SHALL be defined as adv = ce & (~vld[NUM_STAGE-1] | out_ready); in_ready SHALL equal adv.
REQ-020 Transfer SHALL occur when in_valid & in_ready; the operands, op_signed and the valid bit SHALL then enter stage 0.
REQ-021 A bubble SHALL enter stage 0 when adv=1 and in_valid=0.
REQ-022 When adv=1 all stages SHALL shift by one; when adv=0 every stage, including dout, SHALL hold.
REQ-023 Latency SHALL be exactly NUM_STAGE adv-cycles from transfer to out_valid=1; with ce=1 and out_ready=1 throughput SHALL be one result per cycle.
REQ-024 out_valid and dout SHALL stay stable while out_valid=1 and out_ready=0; there SHALL be no combinational path from out_ready to dout.
REQ-025 Without saturation (see Configuration), dout SHALL be P[dout_WIDTH-1:0].
REQ-026 ovf SHALL be 1 when P is not representable in dout_WIDTH bits, using the signedness of the result.
REQ-027 Results SHALL leave in acceptance order; none SHALL be lost or duplicated.
REQ-028 When out_valid=1, out_ready=1 and in_valid=1 all occur in the same cycle, the output SHALL retire and the new input SHALL be accepted in that same cycle.

Reset
REQ-029 When reset=1 at a clk edge, all valid bits SHALL clear, regardless of ce.
REQ-030 The reset values SHALL be out_valid=0, dout=0 and ovf=0; in_ready SHALL reflect ce one cycle after reset.
REQ-031 Reset applied mid-operation SHALL discard all in-flight results; no out_valid SHALL appear from them.

Configuration
REQ-032 With macro CASE_3_MUL_SAT_EN defined, an out-of-range product SHALL clamp dout to the most positive or most negative value for signed mode, or to all ones for unsigned mode; ovf behaviour SHALL be unchanged.
REQ-033 With CASE_3_MUL_SAT_EN undefined, dout SHALL wrap per REQ-025 and no saturation logic SHALL be synthesised.

Structure
REQ-034 Package case_3_mul_pkg SHALL hold the stage record typedef (valid, mode, product), the constant MAX_STAGE=8 and a function returning the P width.
REQ-035 Sub-module case_3_mul_pipe_stage SHALL implement one register stage with the hold-on-~adv behaviour; the top SHALL instantiate it NUM_STAGE times by generate.
REQ-036 The multiply SHALL be placed before stage 0 so that retiming can balance it across the stages.

Verification
REQ-037 Directed signed test: NUM_STAGE=3, op_signed=1, din0=-5, din1=7 with out_ready=1 -> after 3 cycles out_valid=1, dout=-35, ovf=0.
REQ-038 Directed unsigned test: op_signed=0, din0=14'h3FFF, din1=12'hFFF, dout_WIDTH=26 -> dout=0x3FFB001, ovf=0.
REQ-039 Back-pressure test: stream 6 operands with out_ready=0 -> exactly NUM_STAGE accepted, in_ready=0, dout stable; release out_ready -> all 6 results emerge in order.
REQ-040 Overflow test with dout_WIDTH=8, signed 100*100 -> ovf=1, dout=8'h10 without CASE_3_MUL_SAT_EN and 8'h7F with it.
REQ-041 Clock-enable test: toggle ce=0 for 2 cycles mid-stream -> latency extends by 2 cycles and results are unchanged.
REQ-042 Reset test: assert reset for 1 cycle with 3 results in flight -> out_valid=0 next cycle, and no stale results appear afterwards.

Source files
------------

// File: rtl/case_3_mul_pkg.sv
// Shared types and constants for the case_3_mul pipelined multiplier.
//   MAX_STAGE  : deepest supported pipeline
//   PROD_W     : carried product width; the operand product is sign/zero
//                extended into it so range checks never need a special case
//   stage_t    : one pipeline register record {valid, mode, product}
//   prod_width : full product width for a given operand pair
package case_3_mul_pkg;

  localparam int unsigned MAX_STAGE = 8;
  localparam int unsigned PROD_W    = 72;

  typedef struct packed {
    logic              valid;
    logic              mode;     // 1: signed operands, 0: unsigned
    logic [PROD_W-1:0] product;
  } stage_t;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

endpackage

// File: rtl/case_3_mul_pipe_stage.sv
// One register stage of the multiplier pipeline.
//   clk, reset : rising-edge clock, synchronous active-high reset (clears record)
//   adv        : load d when 1, hold q when 0
//   d, q       : stage record in / out
module case_3_mul_pipe_stage
  import case_3_mul_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   adv,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (adv) begin
      q <= d;
    end
  end

endmodule

// File: rtl/case_3_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   ce                  : clock enable; 0 freezes every stage and drops in_ready
//   in_valid/in_ready   : operand handshake (in_ready == advance)
//   op_signed           : 1 = both operands signed, 0 = unsigned
//   din0, din1          : operands
//   out_valid/out_ready : result handshake
//   dout                : product, truncated or (optionally) saturated
//   ovf                 : product not representable in dout_WIDTH bits
// Optional feature: define CASE_3_MUL_SAT_EN to clamp out-of-range products
// instead of wrapping them.
module case_3_mul_pipe_hs
  import case_3_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_signed,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int P = prod_width(din0_WIDTH, din1_WIDTH);

  // ID is a pure instance tag; it only takes part in the configuration check.
  if (NUM_STAGE < 1 || NUM_STAGE > int'(MAX_STAGE) || dout_WIDTH < 2 ||
      dout_WIDTH > P || P >= int'(PROD_W) || ID < 0) begin : g_illegal_config
    $error("case_3_mul_pipe_hs: illegal parameter combination");
  end

  logic   adv;
  stage_t s0;
  stage_t last;
  stage_t stg_d [NUM_STAGE];
  stage_t stg_q [NUM_STAGE];

  assign adv      = ce & (~last.valid | out_ready);
  assign in_ready = adv;

  // Multiply ahead of stage 0; the register chain behind it lets retiming
  // spread the array across the stages.
  logic [P-1:0] a_ext;
  logic [P-1:0] b_ext;
  logic [P-1:0] prod;

  assign a_ext = {{(P-din0_WIDTH){din0[din0_WIDTH-1] & op_signed}}, din0};
  assign b_ext = {{(P-din1_WIDTH){din1[din1_WIDTH-1] & op_signed}}, din1};
  assign prod  = a_ext * b_ext;

  always_comb begin
    s0         = '0;
    s0.valid   = in_valid;
    s0.mode    = op_signed;
    s0.product = {{(int'(PROD_W)-P){prod[P-1] & op_signed}}, prod};
  end

  for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stg_d[i] = s0;
    end else begin : g_link
      assign stg_d[i] = stg_q[i-1];
    end
    case_3_mul_pipe_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .adv   (adv),
      .d     (stg_d[i]),
      .q     (stg_q[i])
    );
  end

  assign last = stg_q[NUM_STAGE-1];

  // Range check on the extended product: signed results fit when every bit
  // from the dout sign position upward agrees; unsigned when all are zero.
  logic [PROD_W-1:0] r;
  logic              fits_s;
  logic              fits_u;
  logic              range_bad;

  assign r         = last.product;
  assign fits_s    = (&r[PROD_W-1:dout_WIDTH-1]) | ~(|r[PROD_W-1:dout_WIDTH-1]);
  assign fits_u    = ~(|r[PROD_W-1:dout_WIDTH]);
  assign range_bad = last.mode ? ~fits_s : ~fits_u;

  assign out_valid = last.valid;
  assign ovf       = last.valid & range_bad;

`ifdef CASE_3_MUL_SAT_EN
  always_comb begin
    dout = r[dout_WIDTH-1:0];
    if (range_bad) begin
      if (last.mode) begin
        dout = r[PROD_W-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                           : {1'b0, {(dout_WIDTH-1){1'b1}}};
      end else begin
        dout = '1;
      end
    end
  end
`else
  assign dout = r[dout_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_case_3_mul_pipe_hs.sv
module tb_case_3_mul_pipe_hs;

`ifdef CASE_3_MUL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // wide instance: 14x12 -> 26, 3 stages
  logic        m_ce, m_in_valid, m_in_ready, m_op_signed, m_out_valid, m_out_ready, m_ovf;
  logic [13:0] m_din0;
  logic [11:0] m_din1;
  logic [25:0] m_dout;
  // narrow instance: 14x12 -> 8, 3 stages
  logic        s_ce, s_in_valid, s_in_ready, s_op_signed, s_out_valid, s_out_ready, s_ovf;
  logic [13:0] s_din0;
  logic [11:0] s_din1;
  logic [7:0]  s_dout;

  case_3_mul_pipe_hs #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26)) dut_main (
    .clk(clk), .reset(reset), .ce(m_ce), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .op_signed(m_op_signed), .din0(m_din0), .din1(m_din1), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .dout(m_dout), .ovf(m_ovf));

  case_3_mul_pipe_hs #(.ID(2), .NUM_STAGE(3), .din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(8)) dut_narrow (
    .clk(clk), .reset(reset), .ce(s_ce), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .op_signed(s_op_signed), .din0(s_din0), .din1(s_din1), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .dout(s_dout), .ovf(s_ovf));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          narrow;
    bit          sgn;
    logic [13:0] a;
    logic [11:0] b;
    logic [25:0] d;
    bit          o;
  } vec_t;

  vec_t vt [16];

  // One isolated transaction; expects result exactly 3 edges after transfer.
  task automatic run_one(input int k);
    int lat;
    logic ov;
    lat = -1;
    for (int c = 0; c < 10 && lat < 0; c++) begin
      @(negedge clk);
      if (vt[k].narrow) begin
        s_in_valid = (c == 0); s_op_signed = vt[k].sgn; s_din0 = vt[k].a; s_din1 = vt[k].b;
      end else begin
        m_in_valid = (c == 0); m_op_signed = vt[k].sgn; m_din0 = vt[k].a; m_din1 = vt[k].b;
      end
      #1;
      if (c == 0) chk($sformatf("vec%0d in_ready", k), vt[k].narrow ? s_in_ready : m_in_ready, 1);
      ov = vt[k].narrow ? s_out_valid : m_out_valid;
      if (ov) begin
        lat = c;
        chk($sformatf("vec%0d dout", k), vt[k].narrow ? {18'd0, s_dout} : m_dout, vt[k].d);
        chk($sformatf("vec%0d ovf", k), vt[k].narrow ? s_ovf : m_ovf, vt[k].o);
      end
    end
    chk($sformatf("vec%0d latency", k), lat, 3);
    @(negedge clk);
    s_in_valid = 0; m_in_valid = 0;
  endtask

  // Stream n unsigned ops with out_ready=1; ce held low for g cycles from cycle g0.
  task automatic stream(input int n, input int g0, input int g);
    logic [25:0] ex [8];
    int idx, rx, last;
    logic rdy;
    idx = 0; rx = 0; last = -1;
    for (int i = 0; i < n; i++) ex[i] = 26'((200 + i) * (5 + 2 * i));
    for (int c = 0; c < 40 && rx < n; c++) begin
      @(negedge clk);
      m_ce = !(c >= g0 && c < g0 + g);
      m_out_ready = 1; m_op_signed = 0;
      m_in_valid = (idx < n);
      m_din0 = 14'(200 + idx); m_din1 = 12'(5 + 2 * idx);
      #1;
      rdy = m_in_ready;
      if (!m_ce) chk($sformatf("stream ce-off in_ready c%0d", c), rdy, 0);
      if (m_out_valid && m_ce) begin
        chk($sformatf("stream dout #%0d", rx), m_dout, ex[rx]);
        if (rx == n - 1) last = c;
        rx++;
      end
      if (m_in_valid && rdy) idx++;
    end
    chk("stream results", rx, n);
    chk("stream last cycle", last, n + 2 + g);
    @(negedge clk);
    m_in_valid = 0; m_ce = 1;
  endtask

  initial begin : main
    logic [25:0] bp [6];
    int idx, rx, seen;

    vt[0]  = '{0, 1, 14'h3FFB, 12'h007, 26'h3FFFFDD, 0};   // -5 * 7 = -35
    vt[1]  = '{0, 0, 14'h3FFF, 12'hFFF, 26'h3FFB001, 0};   // max unsigned
    vt[2]  = '{0, 1, 14'h3FFF, 12'hFFF, 26'h0000001, 0};   // -1 * -1
    vt[3]  = '{0, 1, 14'h2000, 12'h800, 26'h1000000, 0};   // min * min
    vt[4]  = '{0, 1, 14'h2000, 12'h7FF, 26'h3002000, 0};   // min * max
    vt[5]  = '{0, 0, 14'h0000, 12'hABC, 26'h0000000, 0};
    vt[6]  = '{0, 0, 14'h2000, 12'h800, 26'h1000000, 0};
    vt[7]  = '{0, 1, 14'h1FFF, 12'h7FF, 26'h0FFD801, 0};   // max * max signed
    vt[8]  = '{1, 1, 14'h0064, 12'h064, SAT ? 26'h7F : 26'h10, 1};  // 100*100
    vt[9]  = '{1, 1, 14'h3F9C, 12'h064, SAT ? 26'h80 : 26'hF0, 1};  // -100*100
    vt[10] = '{1, 1, 14'h000B, 12'h00B, 26'h79, 0};                 // 121
    vt[11] = '{1, 1, 14'h0008, 12'h010, SAT ? 26'h7F : 26'h80, 1};  // 128
    vt[12] = '{1, 1, 14'h3FF8, 12'h010, 26'h80, 0};                 // -128
    vt[13] = '{1, 0, 14'h000F, 12'h011, 26'hFF, 0};                 // 255
    vt[14] = '{1, 0, 14'h0010, 12'h010, SAT ? 26'hFF : 26'h00, 1};  // 256
    vt[15] = '{1, 1, 14'h3FFF, 12'hFFF, 26'h01, 0};

    reset = 1;
    m_ce = 1; m_in_valid = 0; m_op_signed = 0; m_din0 = '0; m_din1 = '0; m_out_ready = 1;
    s_ce = 1; s_in_valid = 0; s_op_signed = 0; s_din0 = '0; s_din1 = '0; s_out_ready = 1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", m_out_valid, 0);
    chk("reset dout", m_dout, 0);
    chk("reset ovf", m_ovf, 0);
    reset = 0;
    #1 chk("post-reset in_ready ce=1", m_in_ready, 1);
    m_ce = 0;
    #1 chk("in_ready ce=0", m_in_ready, 0);
    m_ce = 1;

    for (int k = 0; k < 16; k++) run_one(k);

    // back-pressure: only NUM_STAGE operands fit while out_ready=0
    for (int k = 0; k < 6; k++) bp[k] = 26'((100 + k) * (3 + k));
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      m_out_ready = 0; m_op_signed = 0;
      m_in_valid = (idx < 6); m_din0 = 14'(100 + idx); m_din1 = 12'(3 + idx);
      #1;
      if (c >= 3) begin
        chk($sformatf("bp stall in_ready c%0d", c), m_in_ready, 0);
        chk($sformatf("bp stall out_valid c%0d", c), m_out_valid, 1);
        chk($sformatf("bp stall dout c%0d", c), m_dout, bp[0]);
      end
      if (m_in_valid && m_in_ready) idx++;
    end
    chk("bp accepted", idx, 3);
    rx = 0;
    for (int c = 0; c < 30 && rx < 6; c++) begin
      @(negedge clk);
      m_out_ready = 1;
      m_in_valid = (idx < 6); m_din0 = 14'(100 + idx); m_din1 = 12'(3 + idx);
      #1;
      if (m_out_valid) begin
        chk($sformatf("bp dout #%0d", rx), m_dout, bp[rx]);
        rx++;
      end
      if (m_in_valid && m_in_ready) idx++;
    end
    chk("bp results", rx, 6);
    @(negedge clk);
    m_in_valid = 0;

    stream(5, 99, 0);   // full throughput, simultaneous retire/accept
    stream(5, 2, 2);    // ce low 2 cycles mid-stream

    // reset with 3 results in flight
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m_in_valid = 1; m_op_signed = 0; m_din0 = 14'(7 + c); m_din1 = 12'd9; m_out_ready = 1;
    end
    @(negedge clk);
    m_in_valid = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk("mid reset out_valid", m_out_valid, 0);
    chk("mid reset dout", m_dout, 0);
    chk("mid reset ovf", m_ovf, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (m_out_valid) seen++;
    end
    chk("stale results after reset", seen, 0);
    run_one(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
